// File: rtl/bcd_xs3_pkg.sv
// Shared constants for the BCD -> Excess-3 sequencing controller: FSM state codes
// and digit encoding constants.
package bcd_xs3_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] XS3_OFFSET    = 4'd3;
    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

    function automatic logic digit_out_of_range(input logic [3:0] d);
        return (d > BCD_MAX_DIGIT);
    endfunction

endpackage

// File: rtl/bcd_xs3_seq_ctrl_enc.sv
// Single-digit Excess-3 encoder, time-shared by the controller.
// Out-of-range digits wrap modulo 16 (10..15 -> 13,14,15,0,1,2).
module xs3_digit_enc
    import bcd_xs3_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_xs3
);

    assign o_xs3 = i_digit + XS3_OFFSET;

endmodule

// File: rtl/bcd_xs3_seq_ctrl.sv
// Multi-digit BCD -> Excess-3 sequencer: one digit per cycle, LSD first, valid/ready on both sides.
// Optional macro BCD_XS3_ERR_CHECK_EN adds a sticky out-of-range digit flag on err.
module bcd_xs3_seq_ctrl
    import bcd_xs3_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DW         = 4 * NUM_DIGITS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_bcd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_xs3,
    output logic          busy,
    output logic          err
);

    localparam int CNT_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_DIGITS - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [DW-1:0]    r_shift;
    logic [DW-1:0]    r_result;

    logic [3:0]       w_digit;
    logic [3:0]       w_xs3;
    logic             w_accept;
    logic             w_last;

    assign w_digit  = r_shift[3:0];
    assign w_accept = in_valid && (r_state == ST_IDLE);
    assign w_last   = (r_cnt == CNT_LAST);

    xs3_digit_enc u_enc (
        .i_digit (w_digit),
        .o_xs3   (w_xs3)
    );

    // The shift register always presents the next digit to convert at its low nibble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_shift  <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_shift  <= in_bcd;
                        r_result <= '0;
                        r_cnt    <= '0;
                        r_state  <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (r_cnt == CNT_W'(i)) begin
                            r_result[4*i +: 4] <= w_xs3;
                        end
                    end
                    r_shift <= r_shift >> 4;
                    if (w_last) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef BCD_XS3_ERR_CHECK_EN
    logic r_err;

    // Sticky across the word; cleared only when the next word is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= 1'b0;
        end else if (r_state == ST_CONV) begin
            r_err <= r_err | digit_out_of_range(w_digit);
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state == ST_CONV) || (r_state == ST_DONE);
    assign out_xs3   = r_result;

endmodule

// File: tb/tb_bcd_xs3_seq_ctrl.sv
// Scoreboard bench for bcd_xs3_seq_ctrl: randomized and directed words, a decoupled output
// monitor, plus a second 2-digit instance.
module tb_bcd_xs3_seq_ctrl;

    localparam int ND  = 4;
    localparam int DW  = 4 * ND;
    localparam int ND2 = 2;
    localparam int DW2 = 4 * ND2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_bcd = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_xs3;
    logic          busy;
    logic          err;

    logic           in_valid2 = 1'b0;
    logic           in_ready2;
    logic [DW2-1:0] in_bcd2 = '0;
    logic           out_valid2;
    logic           out_ready2 = 1'b1;
    logic [DW2-1:0] out_xs32;
    logic           busy2;
    logic           err2;

    always #5 clk = ~clk;

    bcd_xs3_seq_ctrl #(.NUM_DIGITS(ND)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_bcd(in_bcd),
        .out_valid(out_valid), .out_ready(out_ready), .out_xs3(out_xs3), .busy(busy), .err(err)
    );

    bcd_xs3_seq_ctrl #(.NUM_DIGITS(ND2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_bcd(in_bcd2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_xs3(out_xs32), .busy(busy2), .err(err2)
    );

    typedef struct {
        logic [DW-1:0] xs3;
        logic          err;
        int            acc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic prev_valid = 1'b0;
    bit   rand_bp = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Reference: each digit independently plus three, wrapping within four bits
    function automatic logic [DW-1:0] ref_xs3(input logic [DW-1:0] b);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'((int'(b[4*i +: 4]) + 3) % 16);
        end
        return r;
    endfunction

    function automatic logic ref_err(input logic [DW-1:0] b);
        logic e;
        e = 1'b0;
`ifdef BCD_XS3_ERR_CHECK_EN
        for (int i = 0; i < ND; i++) begin
            if (int'(b[4*i +: 4]) > 9) e = 1'b1;
        end
`endif
        return e;
    endfunction

    task automatic send(input logic [DW-1:0] w);
        int   n;
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        in_bcd   = w;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            fail_now("accept_timeout");
            in_valid = 1'b0;
        end else begin
            e.xs3 = ref_xs3(w);
            e.err = ref_err(w);
            e.acc = cyc + 1;
            @(posedge clk);
            sb.push_back(e);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            fail_now("drain_timeout");
            sb.delete();
        end
    endtask

    // Monitor: latency on the rising out_valid, data on handshake, stability while stalled
    always @(negedge clk) begin
        if (rst) begin
            prev_valid <= 1'b0;
        end else begin
            if (out_valid && sb.size() == 0) begin
                fail_now("unexpected_out_valid");
            end else if (out_valid) begin
                if (!prev_valid) chk("latency", 64'(cyc - sb[0].acc), 64'(ND));
                if (out_ready) begin
                    chk("out_xs3", 64'(out_xs3), 64'(sb[0].xs3));
                    chk("err", 64'(err), 64'(sb[0].err));
                    void'(sb.pop_front());
                end else begin
                    chk("hold_xs3", 64'(out_xs3), 64'(sb[0].xs3));
                    chk("hold_err", 64'(err), 64'(sb[0].err));
                    chk("hold_in_ready", 64'(in_ready), 64'd0);
                end
            end
            prev_valid <= out_valid;
        end
    end

    always @(posedge clk) begin
        if (rand_bp) begin
            #1;
            if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] w;
        int n;
        int acc2;

        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_xs3", 64'(out_xs3), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Basic word, then busy/in_ready during conversion
        send(16'h1234);
        @(negedge clk);
        chk("conv_busy", 64'(busy), 64'd1);
        chk("conv_in_ready", 64'(in_ready), 64'd0);
        wait_drain();

        send(16'h0000);
        send(16'h9999);
        send(16'h12A4);
        send(16'h0001);
        wait_drain();

        // Backpressure with ignored in_valid pulses
        @(posedge clk); #1 out_ready = 1'b0;
        send(16'h1234);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            in_valid = (k == 1 || k == 2);
            in_bcd   = 16'hFFFF;
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_release_in_ready", 64'(in_ready), 64'd1);
        chk("post_release_out_valid", 64'(out_valid), 64'd0);
        chk("idle_holds_xs3", 64'(out_xs3), 64'h4567);
        wait_drain();

        // Asynchronous reset mid-conversion
        send(16'h4321);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        sb.delete();
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_out_xs3", 64'(out_xs3), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_err", 64'(err), 64'd0);
        @(negedge clk);
        #3 rst = 1'b0;
        send(16'h5678);
        wait_drain();

        // Randomized words with random backpressure
        rand_bp = 1'b1;
        for (int k = 0; k < 25; k++) begin
            for (int d = 0; d < ND; d++) begin
                w[4*d +: 4] = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15))
                                                          : 4'($urandom_range(0, 9));
            end
            send(w);
        end
        wait_drain();
        rand_bp = 1'b0;
        @(posedge clk); #2 out_ready = 1'b1;

        // Two-digit instance
        @(negedge clk);
        chk("nd2_in_ready", 64'(in_ready2), 64'd1);
        in_valid2 = 1'b1;
        in_bcd2   = 8'h47;
        @(posedge clk);
        #1;
        acc2 = cyc;
        in_valid2 = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid2 && n < 20);
        if (!out_valid2) begin
            fail_now("nd2_timeout");
        end else begin
            chk("nd2_latency", 64'(cyc - acc2), 64'(ND2));
            chk("nd2_out_xs3", 64'(out_xs32), 64'h7A);
            chk("nd2_err", 64'(err2), 64'd0);
        end
        @(negedge clk);
        chk("nd2_back_idle", 64'(in_ready2), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
